// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state, op classification.
// Optional multiply-accumulate ops are enabled by defining MDU_MADD_EN.
package mdu_ctrl_pkg;

    localparam int MDU_OP_LEN = 4;
    localparam int MDU_CNT_W  = 5;

    // Bounds the hazard unit uses when estimating an MDU stall.
    localparam int MDU_OP_STALL_MIN = 1;
    localparam int MDU_OP_STALL_MAX = 31;

    typedef enum logic [MDU_OP_LEN-1:0] {
        MDU_OP_NONE  = 4'd0,
        MDU_OP_MULT  = 4'd1,
        MDU_OP_MULTU = 4'd2,
        MDU_OP_DIV   = 4'd3,
        MDU_OP_DIVU  = 4'd4,
        MDU_OP_MTHI  = 4'd5,
        MDU_OP_MTLO  = 4'd6,
        MDU_OP_MADD  = 4'd7,
        MDU_OP_MADDU = 4'd8,
        MDU_OP_MSUB  = 4'd9,
        MDU_OP_MSUBU = 4'd10
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Ops that take the multiply latency; accumulate ops only exist when enabled.
    function automatic logic is_mul_op(input logic [MDU_OP_LEN-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            MDU_OP_MULT, MDU_OP_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
            MDU_OP_MADD, MDU_OP_MADDU, MDU_OP_MSUB, MDU_OP_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [MDU_OP_LEN-1:0] op);
        return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Issue/result bundle between the execute stage and the MDU controller.
// start is a one-cycle strobe honoured only while busy is low; done pulses once per committed long op.
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    logic                  start;
    logic [MDU_OP_LEN-1:0] op;
    logic [31:0]           src0;
    logic [31:0]           src1;
    logic                  cancel;
    logic                  busy;
    logic                  done;
    logic [31:0]           hi;
    logic [31:0]           lo;

    modport master (output start, op, src0, src1, cancel,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, src0, src1, cancel,
                    output busy, done, hi, lo);
endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational datapath producing the pending {hi,lo} for an MDU op.
// Accumulate ops (MADD family) are built only when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [MDU_OP_LEN-1:0] op_i,
    input  logic [31:0]           src0_i,
    input  logic [31:0]           src1_i,
    input  logic [63:0]           hilo_i,
    output logic [63:0]           res_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sdiv;
    logic [31:0] mag0, mag1, quo_mag, rem_mag, quo, rem;

    assign prod_s = {{32{src0_i[31]}}, src0_i} * {{32{src1_i[31]}}, src1_i};
    assign prod_u = {32'd0, src0_i} * {32'd0, src1_i};

    // One unsigned divider serves both DIV and DIVU; 0x80000000/-1 falls out as 0x80000000 rem 0.
    always_comb begin
        sdiv    = (op_i == MDU_OP_DIV);
        mag0    = (sdiv && src0_i[31]) ? (~src0_i + 32'd1) : src0_i;
        mag1    = (sdiv && src1_i[31]) ? (~src1_i + 32'd1) : src1_i;
        quo_mag = '0;
        rem_mag = '0;
        if (mag1 != 32'd0) begin
            quo_mag = mag0 / mag1;
            rem_mag = mag0 % mag1;
        end
        quo = (sdiv && (src0_i[31] ^ src1_i[31])) ? (~quo_mag + 32'd1) : quo_mag;
        rem = (sdiv && src0_i[31]) ? (~rem_mag + 32'd1) : rem_mag;
    end

    // Default keeps the current HI/LO, which is also the divide-by-zero result.
    always_comb begin
        res_o = hilo_i;
        case (op_i)
            MDU_OP_MULT:  res_o = prod_s;
            MDU_OP_MULTU: res_o = prod_u;
            MDU_OP_DIV, MDU_OP_DIVU: begin
                if (src1_i != 32'd0) res_o = {rem, quo};
            end
`ifdef MDU_MADD_EN
            MDU_OP_MADD:  res_o = hilo_i + prod_s;
            MDU_OP_MADDU: res_o = hilo_i + prod_u;
            MDU_OP_MSUB:  res_o = hilo_i - prod_s;
            MDU_OP_MSUBU: res_o = hilo_i - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller: owns HI/LO, models latency with a countdown.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU ops.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus,
    output mdu_state_e state_o
);

    mdu_state_e           state_q;
    logic [MDU_CNT_W-1:0] cnt_q;
    logic [63:0]          pend_q;
    logic [63:0]          pend_d;
    logic [31:0]          hi_q, lo_q;
    logic                 busy_q, done_q;

    mdu_arith u_arith (
        .op_i   (bus.op),
        .src0_i (bus.src0),
        .src1_i (bus.src1),
        .hilo_i ({hi_q, lo_q}),
        .res_o  (pend_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        if (is_mul_op(bus.op) || is_div_op(bus.op)) begin
                            pend_q  <= pend_d;
                            cnt_q   <= is_div_op(bus.op) ? MDU_CNT_W'(DIV_CYCLES)
                                                         : MDU_CNT_W'(MUL_CYCLES);
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else if (bus.op == MDU_OP_MTHI) begin
                            hi_q <= bus.src0;
                        end else if (bus.op == MDU_OP_MTLO) begin
                            lo_q <= bus.src0;
                        end
                    end
                end
                ST_RUN: begin
                    // Cancel wins even on the final count, so a flushed op never commits.
                    if (bus.cancel) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == MDU_CNT_W'(1)) begin
                        hi_q    <= pend_q[63:32];
                        lo_q    <= pend_q[31:0];
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - MDU_CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed test-plan steps plus random ops against a longint reference model.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic       clk = 1'b0;
    logic       reset;
    mdu_state_e state_dbg;

    always #5 clk = ~clk;

    mdu_ctrl_if bus ();

    mdu_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .state_o (state_dbg)
    );

    int          pass_cnt  = 0;
    int          check_cnt = 0;
    logic [63:0] m_hilo;
    logic [63:0] exp_q[$];

    // Reference model: architectural effect of one op on {hi,lo}, in 64-bit integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] cur);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = cur;
        case (op)
            4'd1: res = sa * sb;
            4'd2: res = ua * ub;
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            4'd4: if (b != 0) begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
            4'd5: res = {a, cur[31:0]};
            4'd6: res = {cur[63:32], a};
`ifdef MDU_MADD_EN
            4'd7:  res = cur + sa * sb;
            4'd8:  res = cur + ua * ub;
            4'd9:  res = cur - sa * sb;
            4'd10: res = cur - ua * ub;
`endif
            default: ;
        endcase
        return res;
    endfunction

    function automatic int ref_latency(input logic [3:0] op);
        case (op)
            4'd1, 4'd2: return MUL_N;
            4'd3, 4'd4: return DIV_N;
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: return MUL_N;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drive one start strobe on a falling edge; returns one falling edge after the sampling edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cancel);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.src0   = a;
        bus.src1   = b;
        bus.cancel = cancel;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = 4'd0;
    endtask

    task automatic exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
        int          n;
        int          cyc;
        logic        early_done;
        logic [63:0] exp;
        n   = ref_latency(op);
        exp = ref_result(op, a, b, m_hilo);
        issue(op, a, b, 1'b0);
        if (n == 0) begin
            check({tag, " busy"}, 64'(bus.busy), 64'd0);
            check({tag, " done"}, 64'(bus.done), 64'd0);
            check({tag, " hilo"}, {bus.hi, bus.lo}, exp);
        end else begin
            exp_q.push_back(exp);
            cyc = 0;
            early_done = 1'b0;
            while (bus.busy === 1'b1 && cyc < 64) begin
                if (bus.done !== 1'b0) early_done = 1'b1;
                cyc++;
                @(negedge clk);
            end
            check({tag, " busy_cycles"}, 64'(cyc), 64'(n));
            check({tag, " done_during_busy"}, 64'(early_done), 64'd0);
            check({tag, " done"}, 64'(bus.done), 64'd1);
            check({tag, " hilo"}, {bus.hi, bus.lo}, exp_q.pop_front());
            @(negedge clk);
            check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
        end
        m_hilo = exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        // Clock/reset
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 4'd0;
        bus.src0   = '0;
        bus.src1   = '0;
        bus.cancel = 1'b0;
        m_hilo     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst busy",  64'(bus.busy), 64'd0);
        check("rst done",  64'(bus.done), 64'd0);
        check("rst hi",    64'(bus.hi), 64'd0);
        check("rst lo",    64'(bus.lo), 64'd0);
        check("rst state", 64'(state_dbg), 64'(ST_IDLE));

        // Basic arithmetic
        exec(4'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg");
        check("mult_neg const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        exec(4'd4, 32'd100, 32'd7, "divu");
        check("divu const", {bus.hi, bus.lo}, {32'd2, 32'd14});
        exec(4'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
        check("div_neg const", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // Divide by zero leaves HI/LO alone
        exec(4'd5, 32'h1234, 32'd0, "mthi");
        exec(4'd6, 32'h5678, 32'd0, "mtlo");
        exec(4'd3, 32'd99, 32'd0, "div0");
        check("div0 const", {bus.hi, bus.lo}, {32'h1234, 32'h5678});

        // Signed overflow
        exec(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div_ovf const", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});

        // Cancel mid-run, with an ignored start while busy
        exec(4'd5, 32'hAAAA, 32'd0, "mthi2");
        exec(4'd6, 32'hBBBB, 32'd0, "mtlo2");
        issue(4'd1, 32'd6, 32'd7, 1'b0);
        bus.start = 1'b1;
        bus.op    = 4'd6;
        bus.src0  = 32'hDEAD;
        @(negedge clk);
        bus.start = 1'b0;
        check("ign busy", 64'(bus.busy), 64'd1);
        check("ign lo",   64'(bus.lo), 64'hBBBB);
        @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel busy",  64'(bus.busy), 64'd0);
        check("cancel done",  64'(bus.done), 64'd0);
        check("cancel hilo",  {bus.hi, bus.lo}, m_hilo);
        check("cancel state", 64'(state_dbg), 64'(ST_IDLE));
        @(negedge clk);
        check("cancel done2", 64'(bus.done), 64'd0);
        check("cancel hilo2", {bus.hi, bus.lo}, {32'hAAAA, 32'hBBBB});

        // Cancel on the final count suppresses the commit
        issue(4'd1, 32'd9, 32'd9, 1'b0);
        repeat (MUL_N - 1) @(negedge clk);
        check("last busy", 64'(bus.busy), 64'd1);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("last_cancel busy", 64'(bus.busy), 64'd0);
        check("last_cancel done", 64'(bus.done), 64'd0);
        check("last_cancel hilo", {bus.hi, bus.lo}, m_hilo);

        // Reset during a divide
        issue(4'd4, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        m_hilo = '0;
        check("rst_mid busy", 64'(bus.busy), 64'd0);
        check("rst_mid done", 64'(bus.done), 64'd0);
        check("rst_mid hilo", {bus.hi, bus.lo}, m_hilo);
        @(negedge clk);
        check("rst_mid done2", 64'(bus.done), 64'd0);

        // Start dropped by a same-cycle cancel
        issue(4'd1, 32'd5, 32'd5, 1'b1);
        check("start_cancel busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("start_cancel busy2", 64'(bus.busy), 64'd0);
        check("start_cancel done",  64'(bus.done), 64'd0);
        check("start_cancel hilo",  {bus.hi, bus.lo}, m_hilo);

        // Multiply-accumulate (no-op unless enabled)
        exec(4'd1, 32'd2, 32'd3, "mult6");
        exec(4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "madd");
`ifdef MDU_MADD_EN
        check("madd const", {bus.hi, bus.lo}, 64'd7);
`else
        check("madd const", {bus.hi, bus.lo}, 64'd6);
`endif

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            exec(rop, ra, rb, "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller in the execute stage.
- Accepts one MDU operation per start pulse and models the fixed iterative latency with a countdown.
- Owns the HI/LO architectural registers and raises busy so the hazard unit stalls later MDU instructions.
- Supports abort via cancel when the issuing instruction is flushed by an exception or interrupt.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (and MADD family); legal range 1..31.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..31.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  issue strobe, sampled at posedge
- op  input  `MDU_OP_LEN  operation code (`MDU_OP_*)
- src0  input  32  rs operand, already forwarded
- src1  input  32  rt operand, already forwarded
- cancel  input  1  abort current or same-cycle operation
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse after HI/LO commit
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: state IDLE, counter 0; busy=0, done=0, hi=0, lo=0. Reset overrides an operation in flight: no commit, next cycle IDLE.
- States:
  - IDLE: accepts start.
  - RUN: counter > 0; pending HI/LO held in internal registers.
- Start in IDLE, cancel=0, op MULT/MULTU/DIV/DIVU:
  - At that posedge, compute the 64-bit product or quotient/remainder into pending registers.
  - Load counter with MUL_CYCLES or DIV_CYCLES; go to RUN.
  - busy is high for exactly N cycles after the edge.
- Arithmetic:
  - MULT: signed 32x32->64. MULTU: unsigned.
  - {hi,lo} = product.
  - DIV: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
  - DIVU: unsigned.
- RUN: counter decrements each cycle. On the edge where the counter goes 1->0, commit pending to hi/lo, set done=1 for the next cycle, busy=0 from that cycle.
- MTHI/MTLO with start in IDLE: write src0 to hi or lo at that edge. No busy, no done.
- start while busy=1: ignored entirely, no queueing. The hazard unit guarantees no such start; the bench checks it is harmless.
- Division by zero (src1=0, DIV/DIVU): runs the full DIV_CYCLES, asserts done, leaves hi/lo unchanged.
- DIV overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- cancel:
  - cancel with start in the same cycle: start dropped.
  - cancel during RUN: next cycle IDLE, busy=0, no commit, no done. hi/lo keep their pre-operation values.
  - cancel in the commit cycle (counter==1): the commit is suppressed.
- Unused op codes with start: no-op.
- MFHI/MFLO are not part of this block: the reader muxes hi/lo directly, and a same-cycle MTHI/MTLO write is visible after the edge.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds ops MADD, MADDU, MSUB, MSUBU.
  - {hi,lo} = {hi,lo} +/- product.
  - Uses the hi/lo value at the start edge; latency MUL_CYCLES.
  - Cancel semantics as above.
- Undefined: those op codes are treated as unused (no-op). The adder is not synthesised.

Decomposition:
- def.v holds `MDU_OP_LEN (4) and the codes:
  - `MDU_OP_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
- def.v also holds `MDU_OP_STALL_MIN/MAX, used by the hazard unit.
- One sub-module is natural: mdu_arith, the combinational 64-bit multiply/divide/accumulate producing pending {hi,lo}. mdu_ctrl holds the FSM, counter and registers.

Test Plan:
- MULT src0=0xFFFFFFFE(-2), src1=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- DIVU src0=100, src1=7 -> busy 10 cycles; then lo=14, hi=2. DIV src0=-7, src1=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV src1=0 after MTHI 0x1234 and MTLO 0x5678 -> busy 10 cycles, done pulses, hi=0x1234 and lo=0x5678 unchanged.
- MULT 6x7 started, cancel at cycle 3 -> busy drops next cycle, no done, hi/lo retain prior values. A second start during busy is ignored.
- Reset asserted mid-DIVU -> next cycle busy=0, hi=lo=0, no done. Start with cancel in the same cycle -> busy stays 0.
- (MDU_MADD_EN) after MULT 2x3, MADD 0xFFFFFFFF x 0xFFFFFFFF (signed -1x-1) -> {hi,lo}=7. Without the macro -> the op is a no-op and {hi,lo}=6.
